// File: rtl/halt_mon_pkg.sv
// halt_mon_pkg: shared types and constants for pipeline_halt_monitor.
//   halt_mon_state_t        monitor FSM states
//   HALT_MON_DEFAULT_INSTR  default end-of-program encoding
//   STG_*                   stage indices of the exported pipeline
//   halt_mon_cnt_w()        bits needed to hold a down-counter preset
package halt_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } halt_mon_state_t;

    localparam logic [31:0] HALT_MON_DEFAULT_INSTR = 32'h0000_0001;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_DE  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int unsigned halt_mon_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/halt_mon_sat_counter.sv
// halt_mon_sat_counter: up-counter that sticks at its all-ones value.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (priority over inc)
//   inc         count enable
//   count       registered count value
module halt_mon_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_halt_monitor.sv
// pipeline_halt_monitor: watches one pipeline stage for the halt encoding,
// drains for DRAIN_CYCLES, then raises a sticky halt flag. Keeps saturating
// cycle and retired-instruction counters over the RUN and DRAIN phases.
// Optional watchdog enabled by defining HALT_MON_TIMEOUT_EN.
//   clk_clk, reset_reset_n  clock, asynchronous active-low reset
//   enable_i                run gate (ignored while draining)
//   clear_i                 synchronous return to IDLE, clears flags/counters
//   instr_i, valid_i        per-stage instruction export, stage s at [s*XLEN +: XLEN]
//   halt_pending_o          draining after a hit
//   halt_o                  sticky program-finished flag
//   timeout_o               sticky watchdog flag (0 without the watchdog)
//   cycle_count_o           cycles spent running or draining
//   retire_count_o          valid WB instructions while running or draining
module pipeline_halt_monitor
    import halt_mon_pkg::*;
#(
    parameter int unsigned     NUM_STAGES     = 5,
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] HALT_INSTR     = XLEN'(HALT_MON_DEFAULT_INSTR),
    parameter int unsigned     HALT_STAGE     = STG_EX,
    parameter int unsigned     DRAIN_CYCLES   = 10,
    parameter int unsigned     CNT_W          = 32,
    parameter int unsigned     TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic [NUM_STAGES*XLEN-1:0] instr_i,
    input  logic [NUM_STAGES-1:0]      valid_i,
    output logic                       halt_pending_o,
    output logic                       halt_o,
    output logic                       timeout_o,
    output logic [CNT_W-1:0]           cycle_count_o,
    output logic [CNT_W-1:0]           retire_count_o
);

    localparam int unsigned DRN_W      = halt_mon_cnt_w(DRAIN_CYCLES);
    localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    // Elaboration-time parameter sanity checks.
    if (HALT_STAGE >= NUM_STAGES) begin : g_bad_stage
        $error("HALT_STAGE must be below NUM_STAGES");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    halt_mon_state_t  state, state_next;
    logic [DRN_W-1:0] drain_cnt, drain_next;
    logic             hit;
    logic             run_en;
    logic             count_en;
    logic             wd_expire;
    logic             unused_bits;

    // Only the watched stage slice and the WB valid are consumed.
    assign unused_bits = ^{instr_i, valid_i};

    assign hit      = valid_i[HALT_STAGE] &&
                      (instr_i[HALT_STAGE*XLEN +: XLEN] == HALT_INSTR);
    assign run_en   = (state == ST_RUN) && enable_i;
    assign count_en = run_en || (state == ST_DRAIN);

    halt_mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (clear_i),
        .inc   (count_en),
        .count (cycle_count_o)
    );

    halt_mon_sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (clear_i),
        .inc   (count_en && valid_i[NUM_STAGES-1]),
        .count (retire_count_o)
    );

`ifdef HALT_MON_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_count;

    // Watchdog counts enabled RUN cycles; a hit on the limit cycle wins.
    halt_mon_sat_counter #(.W(WD_W)) u_wd_cnt (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (clear_i),
        .inc   (run_en && !hit),
        .count (wd_count)
    );

    assign wd_expire = run_en && !hit && (wd_count == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            timeout_o <= 1'b0;
        end else if (clear_i) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= (state == ST_TIMEOUT);
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State and drain-counter registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Next-state logic; clear_i overrides every transition.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (enable_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_en && hit) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = ST_HALTED;
                    end else begin
                        state_next = ST_DRAIN;
                        drain_next = DRN_W'(DRAIN_LOAD);
                    end
                end else if (wd_expire) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = ST_HALTED;
                end else begin
                    drain_next = drain_cnt - DRN_W'(1);
                end
            end
            default: begin
            end
        endcase
        if (clear_i) begin
            state_next = ST_IDLE;
            drain_next = '0;
        end
    end

    // Registered status flags follow the state one cycle later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            halt_pending_o <= 1'b0;
            halt_o         <= 1'b0;
        end else if (clear_i) begin
            halt_pending_o <= 1'b0;
            halt_o         <= 1'b0;
        end else begin
            halt_pending_o <= (state == ST_DRAIN);
            halt_o         <= (state == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_pipeline_halt_monitor.sv
// Bench for pipeline_halt_monitor: two instances share one stimulus stream.
//   A: DRAIN_CYCLES=10, CNT_W=32, TIMEOUT_CYCLES=1000
//   B: DRAIN_CYCLES=0,  CNT_W=4,  TIMEOUT_CYCLES=8
// An event-based model (hit edge, counted edges) predicts every output and is
// compared each falling edge; literal checks pin the model at key points.
module tb_pipeline_halt_monitor;

    localparam int unsigned NS = 5;
    localparam int unsigned XL = 32;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              clear;
    logic [NS*XL-1:0]  instr;
    logic [NS-1:0]     valid;

    logic              a_pending, a_halt, a_timeout;
    logic [31:0]       a_cyc, a_ret;
    logic              b_pending, b_halt, b_timeout;
    logic [3:0]        b_cyc, b_ret;

    int n_assert;
    int n_fail;
    bit cmp_on;

    pipeline_halt_monitor #(
        .NUM_STAGES(NS), .XLEN(XL), .HALT_INSTR(32'h0000_0001), .HALT_STAGE(2),
        .DRAIN_CYCLES(10), .CNT_W(32), .TIMEOUT_CYCLES(1000)
    ) u_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable_i(enable), .clear_i(clear),
        .instr_i(instr), .valid_i(valid),
        .halt_pending_o(a_pending), .halt_o(a_halt), .timeout_o(a_timeout),
        .cycle_count_o(a_cyc), .retire_count_o(a_ret)
    );

    pipeline_halt_monitor #(
        .NUM_STAGES(NS), .XLEN(XL), .HALT_INSTR(32'h0000_0001), .HALT_STAGE(2),
        .DRAIN_CYCLES(0), .CNT_W(4), .TIMEOUT_CYCLES(8)
    ) u_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable_i(enable), .clear_i(clear),
        .instr_i(instr), .valid_i(valid),
        .halt_pending_o(b_pending), .halt_o(b_halt), .timeout_o(b_timeout),
        .cycle_count_o(b_cyc), .retire_count_o(b_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int     m_d [2] = '{10, 0};
    int     m_w [2] = '{32, 4};
    int     m_to[2] = '{1000, 8};
    int     edge_n;
    bit     started [2];
    int     hit_edge[2];
    bit     timed   [2];
    int     to_edge [2];
    int     wd      [2];
    longint cyc     [2];
    longint ret     [2];

    task automatic model_reset(input int i);
        started[i]  = 1'b0;
        hit_edge[i] = -1;
        timed[i]    = 1'b0;
        to_edge[i]  = 0;
        wd[i]       = 0;
        cyc[i]      = 0;
        ret[i]      = 0;
    endtask

    task automatic model_step(input int i);
        bit is_hit, act, drn;
        if (!rst_n || clear) begin
            model_reset(i);
        end else begin
            is_hit = valid[2] && (instr[2*XL +: XL] == 32'h0000_0001);
            act    = started[i] && (hit_edge[i] < 0) && !timed[i] && enable;
            drn    = (hit_edge[i] >= 0) && (edge_n > hit_edge[i]) &&
                     (edge_n <= hit_edge[i] + m_d[i]);
            if (act || drn) begin
                cyc[i]++;
                if (valid[4]) ret[i]++;
            end
            if (act && is_hit) begin
                hit_edge[i] = edge_n;
            end
`ifdef HALT_MON_TIMEOUT_EN
            else if (act) begin
                wd[i]++;
                if (wd[i] == m_to[i]) begin
                    timed[i]   = 1'b1;
                    to_edge[i] = edge_n;
                end
            end
`endif
            if (!started[i] && enable) started[i] = 1'b1;
        end
    endtask

    initial begin
        edge_n = 0;
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            edge_n++;
            model_step(0);
            model_step(1);
        end
    end

    function automatic logic [63:0] exp_pending(input int i);
        return 64'(rst_n && (hit_edge[i] >= 0) && (edge_n >= hit_edge[i] + 1) &&
                   (edge_n <= hit_edge[i] + m_d[i]));
    endfunction

    function automatic logic [63:0] exp_halt(input int i);
        return 64'(rst_n && (hit_edge[i] >= 0) && (edge_n >= hit_edge[i] + m_d[i] + 1));
    endfunction

    function automatic logic [63:0] exp_to(input int i);
        return 64'(rst_n && timed[i] && (edge_n >= to_edge[i] + 1));
    endfunction

    function automatic logic [63:0] exp_cnt(input int i, input longint v);
        longint mx;
        mx = (longint'(1) << m_w[i]) - 1;
        if (!rst_n) return 64'd0;
        return 64'((v > mx) ? mx : v);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("a_pending", 64'(a_pending), exp_pending(0));
                check("a_halt",    64'(a_halt),    exp_halt(0));
                check("a_timeout", 64'(a_timeout), exp_to(0));
                check("a_cycles",  64'(a_cyc),     exp_cnt(0, cyc[0]));
                check("a_retired", 64'(a_ret),     exp_cnt(0, ret[0]));
                check("b_pending", 64'(b_pending), exp_pending(1));
                check("b_halt",    64'(b_halt),    exp_halt(1));
                check("b_timeout", 64'(b_timeout), exp_to(1));
                check("b_cycles",  64'(b_cyc),     exp_cnt(1, cyc[1]));
                check("b_retired", 64'(b_ret),     exp_cnt(1, ret[1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] ins, input logic v);
        instr[2*XL +: XL] = ins;
        valid[2]          = v;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cmp_on   = 1'b1;
        rst_n    = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        instr    = '0;
        valid    = '0;

        // Reset state.
        step(2);
        check("lit_reset_a_halt", 64'(a_halt), 64'd0);
        check("lit_reset_a_cyc",  64'(a_cyc),  64'd0);
        check("lit_reset_b_cyc",  64'(b_cyc),  64'd0);
        rst_n = 1'b1;
        step(1);

        // Run 20 cycles retiring every cycle, no hit.
        valid[4] = 1'b1;
        enable   = 1'b1;
        step(1);
        step(20);
        check("lit_run_a_cyc",  64'(a_cyc),  64'd20);
        check("lit_run_a_ret",  64'(a_ret),  64'd20);
        check("lit_run_a_halt", 64'(a_halt), 64'd0);
`ifdef HALT_MON_TIMEOUT_EN
        check("lit_run_b_timeout", 64'(b_timeout), 64'd1);
`else
        check("lit_run_b_cyc_sat", 64'(b_cyc), 64'd15);
`endif

        // Halt encoding in a bubble is not a hit.
        set_ex(32'h0000_0001, 1'b0);
        step(3);
        check("lit_bubble_a_pend", 64'(a_pending), 64'd0);
        check("lit_bubble_b_halt", 64'(b_halt),    64'd0);

        // Real hit at edge t.
        set_ex(32'h0000_0001, 1'b1);
        step(1);
        set_ex(32'h0, 1'b0);
        check("lit_t_a_pend", 64'(a_pending), 64'd0);
        step(1);
        check("lit_t1_a_pend", 64'(a_pending), 64'd1);
`ifndef HALT_MON_TIMEOUT_EN
        check("lit_t1_b_halt", 64'(b_halt),    64'd1);
`endif
        check("lit_t1_b_pend", 64'(b_pending), 64'd0);
        // Extra hits while draining are ignored.
        step(4);
        set_ex(32'h0000_0001, 1'b1);
        step(2);
        set_ex(32'h0, 1'b0);
        step(3);
        check("lit_t10_a_pend", 64'(a_pending), 64'd1);
        check("lit_t10_a_halt", 64'(a_halt),    64'd0);
        step(1);
        check("lit_t11_a_pend", 64'(a_pending), 64'd0);
        check("lit_t11_a_halt", 64'(a_halt),    64'd1);
        check("lit_t11_a_cyc",  64'(a_cyc),     64'd34);
        step(5);
        check("lit_frozen_a_cyc", 64'(a_cyc), 64'd34);
        check("lit_frozen_a_ret", 64'(a_ret), 64'd34);

        // Clear out of HALTED.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("lit_clr_a_halt", 64'(a_halt), 64'd0);
        check("lit_clr_a_cyc",  64'(a_cyc),  64'd0);
        check("lit_clr_b_halt", 64'(b_halt), 64'd0);

        // Disabled RUN freezes counters.
        step(1);
        enable = 1'b0;
        step(3);
        check("lit_freeze_a_cyc", 64'(a_cyc), 64'd0);
        enable = 1'b1;
        step(4);
        check("lit_resume_a_cyc", 64'(a_cyc), 64'd4);

        // Reset in the middle of DRAIN.
        set_ex(32'h0000_0001, 1'b1);
        step(1);
        set_ex(32'h0, 1'b0);
        step(4);
        check("lit_drain_a_pend", 64'(a_pending), 64'd1);
        rst_n = 1'b0;
        #1;
        check("lit_rst_a_pend", 64'(a_pending), 64'd0);
        check("lit_rst_a_cyc",  64'(a_cyc),     64'd0);
        step(2);
        rst_n  = 1'b1;
        enable = 1'b0;
        step(15);
        check("lit_norelease_a_halt", 64'(a_halt), 64'd0);

`ifdef HALT_MON_TIMEOUT_EN
        // Hit on the watchdog expiry cycle wins.
        enable = 1'b1;
        step(1);
        step(7);
        set_ex(32'h0000_0001, 1'b1);
        step(1);
        set_ex(32'h0, 1'b0);
        step(1);
        check("lit_expiry_b_halt",    64'(b_halt),    64'd1);
        check("lit_expiry_b_timeout", 64'(b_timeout), 64'd0);
        step(3);
`endif

        @(negedge clk);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
